// File: rtl/ide_xfer_sequencer_if.sv
// ide_xfer_sequencer_if
//   Bundles the CPU-side control, host-bus qualifiers and buffer/status outputs of the
//   IDE transfer sequencer.
//   slave  : the sequencer (samples control/bus inputs, drives buffer and status outputs)
//   master : the CPU/host side (drives start/mode/dir/lengths/acks/strobes, observes status)
// Signals:
//   start, mode, dir, xfer_len, blk_len   transfer launch and parameters
//   cpu_ack, abort                        CPU block release / termination pulses
//   bus_strobe, dmack                     host word-cycle pulse and DMACK qualifier
//   buf_addr, buf_we                      buffer word address and write enable
//   drq, dmarq, busy, remaining           status
//   block_irq, done, overrun              event pulses and sticky error flag
interface ide_xfer_sequencer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              start;
  logic              mode;
  logic              dir;
  logic [CNT_W-1:0]  xfer_len;
  logic [ADDR_W:0]   blk_len;
  logic              cpu_ack;
  logic              abort;
  logic              bus_strobe;
  logic              dmack;
  logic [ADDR_W-1:0] buf_addr;
  logic              buf_we;
  logic              drq;
  logic              dmarq;
  logic              busy;
  logic [CNT_W-1:0]  remaining;
  logic              block_irq;
  logic              done;
  logic              overrun;

  modport slave (
    input  start, mode, dir, xfer_len, blk_len, cpu_ack, abort, bus_strobe, dmack,
    output buf_addr, buf_we, drq, dmarq, busy, remaining, block_irq, done, overrun
  );

  modport master (
    output start, mode, dir, xfer_len, blk_len, cpu_ack, abort, bus_strobe, dmack,
    input  buf_addr, buf_we, drq, dmarq, busy, remaining, block_irq, done, overrun
  );
endinterface

// File: rtl/ide_xfer_sequencer.sv
// ide_xfer_sequencer
//   Sequences a PIO or multiword-DMA IDE data transfer between the host bus and a
//   2^ADDR_W x 16-bit data buffer, split into CPU-released blocks.
// Ports:
//   clk      sole clock, rising edge
//   rst      asynchronous active-high reset
//   xfer_if  slave side of ide_xfer_sequencer_if (control in, buffer/status out)
module ide_xfer_sequencer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input logic                 clk,
  input logic                 rst,
  ide_xfer_sequencer_if.slave xfer_if
);

  localparam int unsigned BlkW = ADDR_W + 1;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StBlkWait
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [BlkW-1:0]   blk_cnt_q;
  logic [BlkW-1:0]   blk_len_q;
  logic              mode_q;
  logic              dir_q;
  logic              dmarq_q;
  logic              block_irq_q;
  logic              done_q;
  logic              overrun_q;

  logic              dmack_ok;
  logic              valid_strobe;
  logic [BlkW-1:0]   blk_len_eff;

  always_comb begin
    // PIO words must arrive with DMACK low, DMA words with DMACK high.
    dmack_ok     = mode_q ? xfer_if.dmack : ~xfer_if.dmack;
    // Abort wins over a coincident strobe, so the strobe must not write the buffer.
    valid_strobe = xfer_if.bus_strobe & (state_q == StXfer) & dmack_ok & ~xfer_if.abort;
    // A zero block length encodes a full buffer.
    blk_len_eff  = (xfer_if.blk_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : xfer_if.blk_len;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      buf_addr_q  <= '0;
      remaining_q <= '0;
      blk_cnt_q   <= '0;
      blk_len_q   <= '0;
      mode_q      <= 1'b0;
      dir_q       <= 1'b0;
      dmarq_q     <= 1'b0;
      block_irq_q <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      block_irq_q <= 1'b0;
      done_q      <= 1'b0;
      if (xfer_if.abort) begin
        state_q <= StIdle;
        dmarq_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (xfer_if.start) begin
              if (xfer_if.xfer_len == '0) begin
                done_q <= 1'b1;
              end else begin
                remaining_q <= xfer_if.xfer_len;
                blk_cnt_q   <= blk_len_eff;
                blk_len_q   <= blk_len_eff;
                buf_addr_q  <= '0;
                mode_q      <= xfer_if.mode;
                dir_q       <= xfer_if.dir;
                overrun_q   <= 1'b0;
                dmarq_q     <= xfer_if.mode;
                state_q     <= StXfer;
              end
            end
          end
          StXfer: begin
            // Early negation: drop DMARQ once the host acknowledges the final word.
            if (xfer_if.dmack && (remaining_q == CNT_W'(1))) begin
              dmarq_q <= 1'b0;
            end
            if (valid_strobe) begin
              buf_addr_q  <= buf_addr_q + ADDR_W'(1);
              remaining_q <= remaining_q - CNT_W'(1);
              blk_cnt_q   <= blk_cnt_q - BlkW'(1);
              if (remaining_q == CNT_W'(1)) begin
                state_q <= StIdle;
                done_q  <= 1'b1;
                dmarq_q <= 1'b0;
              end else if (blk_cnt_q == BlkW'(1)) begin
                state_q     <= StBlkWait;
                block_irq_q <= 1'b1;
                dmarq_q     <= 1'b0;
              end
            end else if (xfer_if.bus_strobe) begin
              overrun_q <= 1'b1;
            end
          end
          StBlkWait: begin
            if (xfer_if.bus_strobe) begin
              overrun_q <= 1'b1;
            end
            if (xfer_if.cpu_ack) begin
              blk_cnt_q <= blk_len_q;
              dmarq_q   <= mode_q;
              state_q   <= StXfer;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign xfer_if.buf_addr  = buf_addr_q;
  assign xfer_if.buf_we    = valid_strobe & dir_q;
  assign xfer_if.drq       = (state_q == StXfer) & ~mode_q;
  assign xfer_if.dmarq     = dmarq_q;
  assign xfer_if.busy      = (state_q != StIdle);
  assign xfer_if.remaining = remaining_q;
  assign xfer_if.block_irq = block_irq_q;
  assign xfer_if.done      = done_q;
  assign xfer_if.overrun   = overrun_q;

endmodule

// File: tb/tb_ide_xfer_sequencer.sv
// Bench for ide_xfer_sequencer (ADDR_W=2 so address wrap is reachable quickly).
module tb_ide_xfer_sequencer;
  localparam int unsigned AW    = 2;
  localparam int unsigned CW    = 16;
  localparam int          DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ide_xfer_sequencer_if #(.ADDR_W(AW), .CNT_W(CW)) bus_if ();

  ide_xfer_sequencer #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .xfer_if (bus_if)
  );

  int n_checks = 0;
  int n_err    = 0;
  int seen_done, seen_irq;

  // Transaction-level reference: progress tracked as words completed.
  int m_state;  // 0 idle, 1 transferring, 2 waiting for CPU
  int m_len, m_words, m_blk, m_blkwords;
  bit m_mode, m_dir, m_dmarq, m_irq, m_done, m_ovr;

  typedef struct {
    logic        start, mode, dir;
    logic [15:0] xlen;
    logic [2:0]  blen;
    logic        strobe, dmack, abort;
    logic        e_busy, e_drq, e_we;
    logic [1:0]  e_addr;
    logic [15:0] e_rem;
    logic        e_irq, e_done;
  } vec_t;

  vec_t vecs[7];
  int   wrap_exp[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_len = 0; m_words = 0; m_blk = 0; m_blkwords = 0;
    m_mode = 0; m_dir = 0; m_dmarq = 0; m_irq = 0; m_done = 0; m_ovr = 0;
  endtask

  task automatic clr();
    bus_if.start = 0; bus_if.mode = 0; bus_if.dir = 0; bus_if.xfer_len = '0;
    bus_if.blk_len = '0; bus_if.cpu_ack = 0; bus_if.abort = 0; bus_if.bus_strobe = 0;
    bus_if.dmack = 0;
  endtask

  task automatic model_check();
    bit qual, exp_we;
    qual   = m_mode ? bus_if.dmack : !bus_if.dmack;
    exp_we = bus_if.bus_strobe && (m_state == 1) && qual && !bus_if.abort && m_dir;
    chk("m_busy", {31'd0, bus_if.busy}, {31'd0, m_state != 0});
    chk("m_drq", {31'd0, bus_if.drq}, {31'd0, (m_state == 1) && !m_mode});
    chk("m_dmarq", {31'd0, bus_if.dmarq}, {31'd0, m_dmarq});
    chk("m_buf_we", {31'd0, bus_if.buf_we}, {31'd0, exp_we});
    chk("m_buf_addr", {30'd0, bus_if.buf_addr}, 32'(m_words % DEPTH));
    chk("m_remaining", {16'd0, bus_if.remaining}, 32'((m_len - m_words) & 16'hffff));
    chk("m_block_irq", {31'd0, bus_if.block_irq}, {31'd0, m_irq});
    chk("m_done", {31'd0, bus_if.done}, {31'd0, m_done});
    chk("m_overrun", {31'd0, bus_if.overrun}, {31'd0, m_ovr});
    if (bus_if.done) seen_done++;
    if (bus_if.block_irq) seen_irq++;
  endtask

  task automatic model_step();
    bit qual;
    int rem_before;
    if (rst) begin
      model_reset();
      return;
    end
    m_done = 0;
    m_irq  = 0;
    qual = m_mode ? bus_if.dmack : !bus_if.dmack;
    if (bus_if.abort) begin
      m_state = 0;
      m_dmarq = 0;
    end else if (m_state == 0) begin
      if (bus_if.start) begin
        if (bus_if.xfer_len == 0) begin
          m_done = 1;
        end else begin
          m_len = int'(bus_if.xfer_len); m_words = 0; m_blkwords = 0;
          m_blk = (bus_if.blk_len == 0) ? DEPTH : int'(bus_if.blk_len);
          m_mode = bus_if.mode; m_dir = bus_if.dir; m_ovr = 0;
          m_dmarq = bus_if.mode; m_state = 1;
        end
      end
    end else if (m_state == 1) begin
      rem_before = m_len - m_words;
      if (bus_if.dmack && rem_before == 1) m_dmarq = 0;
      if (bus_if.bus_strobe) begin
        if (qual) begin
          m_words++;
          m_blkwords++;
          if (m_words == m_len) begin
            m_state = 0; m_done = 1; m_dmarq = 0;
          end else if (m_blkwords == m_blk) begin
            m_state = 2; m_irq = 1; m_dmarq = 0; m_blkwords = 0;
          end
        end else begin
          m_ovr = 1;
        end
      end
    end else begin
      if (bus_if.bus_strobe) m_ovr = 1;
      if (bus_if.cpu_ack) begin
        m_state = 1; m_blkwords = 0; m_dmarq = m_mode;
      end
    end
  endtask

  // Inputs are set just after a rising edge; outputs sampled at the falling edge.
  task automatic cyc_begin();
    #4;
    model_check();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick();
    cyc_begin();
    cyc_end();
  endtask

  task automatic do_reset();
    clr();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic launch(input bit md, input bit dr, input int len, input int blen);
    bus_if.start = 1; bus_if.mode = md; bus_if.dir = dr;
    bus_if.xfer_len = CW'(len); bus_if.blk_len = 3'(blen);
    tick();
    clr();
  endtask

  task automatic strobes(input int n, input bit dk);
    bus_if.bus_strobe = 1;
    bus_if.dmack = dk;
    repeat (n) tick();
    bus_if.bus_strobe = 0;
    bus_if.dmack = 0;
  endtask

  initial begin
    // PIO read, xfer_len=4, blk_len=4: start, 4 strobes, then idle.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'd4, 3'd4, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 16'd0, 3'd0, 1'b1, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b0, 2'd0, 16'd4, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 16'd0, 3'd0, 1'b1, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b0, 2'd1, 16'd3, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 16'd0, 3'd0, 1'b1, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b0, 2'd2, 16'd2, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 16'd0, 3'd0, 1'b1, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b0, 2'd3, 16'd1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0};
    wrap_exp = '{0, 1, 2, 3, 0, 1};

    seen_done = 0;
    seen_irq  = 0;
    do_reset();

    // Reset state.
    cyc_begin();
    chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("rst_remaining", {16'd0, bus_if.remaining}, 32'd0);
    chk("rst_dmarq", {31'd0, bus_if.dmarq}, 32'd0);
    chk("rst_overrun", {31'd0, bus_if.overrun}, 32'd0);
    cyc_end();

    // Table-driven PIO read.
    seen_done = 0; seen_irq = 0;
    for (int i = 0; i < 7; i++) begin
      clr();
      bus_if.start = vecs[i].start; bus_if.mode = vecs[i].mode; bus_if.dir = vecs[i].dir;
      bus_if.xfer_len = vecs[i].xlen; bus_if.blk_len = vecs[i].blen;
      bus_if.bus_strobe = vecs[i].strobe; bus_if.dmack = vecs[i].dmack;
      bus_if.abort = vecs[i].abort;
      cyc_begin();
      chk("tv_busy", {31'd0, bus_if.busy}, {31'd0, vecs[i].e_busy});
      chk("tv_drq", {31'd0, bus_if.drq}, {31'd0, vecs[i].e_drq});
      chk("tv_buf_we", {31'd0, bus_if.buf_we}, {31'd0, vecs[i].e_we});
      chk("tv_buf_addr", {30'd0, bus_if.buf_addr}, {30'd0, vecs[i].e_addr});
      chk("tv_remaining", {16'd0, bus_if.remaining}, {16'd0, vecs[i].e_rem});
      chk("tv_block_irq", {31'd0, bus_if.block_irq}, {31'd0, vecs[i].e_irq});
      chk("tv_done", {31'd0, bus_if.done}, {31'd0, vecs[i].e_done});
      cyc_end();
    end
    clr();
    chk("pio_rd_done_count", 32'(seen_done), 32'd1);
    chk("pio_rd_irq_count", 32'(seen_irq), 32'd0);

    // PIO write in blocks of 2.
    seen_done = 0; seen_irq = 0;
    launch(1'b0, 1'b1, 6, 2);
    for (int b = 0; b < 3; b++) begin
      bus_if.bus_strobe = 1;
      for (int w = 0; w < 2; w++) begin
        cyc_begin();
        chk("pio_wr_we", {31'd0, bus_if.buf_we}, 32'd1);
        cyc_end();
      end
      bus_if.bus_strobe = 0;
      cyc_begin();
      if (b < 2) begin
        chk("pio_wr_irq", {31'd0, bus_if.block_irq}, 32'd1);
        chk("pio_wr_drq_wait", {31'd0, bus_if.drq}, 32'd0);
        chk("pio_wr_busy_wait", {31'd0, bus_if.busy}, 32'd1);
      end else begin
        chk("pio_wr_done", {31'd0, bus_if.done}, 32'd1);
        chk("pio_wr_irq_last", {31'd0, bus_if.block_irq}, 32'd0);
      end
      cyc_end();
      if (b < 2) begin
        bus_if.cpu_ack = 1;
        tick();
        bus_if.cpu_ack = 0;
      end
    end
    chk("pio_wr_done_count", 32'(seen_done), 32'd1);
    chk("pio_wr_irq_count", 32'(seen_irq), 32'd2);

    // DMA with early DMARQ negation and a badly qualified strobe.
    seen_done = 0;
    launch(1'b1, 1'b0, 3, 0);
    bus_if.bus_strobe = 1; bus_if.dmack = 0;
    cyc_begin();
    chk("dma_dmarq_on", {31'd0, bus_if.dmarq}, 32'd1);
    cyc_end();
    clr();
    cyc_begin();
    chk("dma_overrun", {31'd0, bus_if.overrun}, 32'd1);
    chk("dma_rem_after_bad", {16'd0, bus_if.remaining}, 32'd3);
    cyc_end();
    strobes(2, 1'b1);
    bus_if.dmack = 1;
    cyc_begin();
    chk("dma_dmarq_before", {31'd0, bus_if.dmarq}, 32'd1);
    cyc_end();
    bus_if.bus_strobe = 1;
    cyc_begin();
    chk("dma_dmarq_early_off", {31'd0, bus_if.dmarq}, 32'd0);
    chk("dma_busy_last", {31'd0, bus_if.busy}, 32'd1);
    cyc_end();
    clr();
    cyc_begin();
    chk("dma_done", {31'd0, bus_if.done}, 32'd1);
    cyc_end();
    chk("dma_done_count", 32'(seen_done), 32'd1);

    // Address wrap with a full-buffer block.
    launch(1'b0, 1'b1, 6, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        cyc_begin();
        chk("wrap_irq", {31'd0, bus_if.block_irq}, 32'd1);
        cyc_end();
        bus_if.cpu_ack = 1;
        tick();
        bus_if.cpu_ack = 0;
      end
      bus_if.bus_strobe = 1;
      cyc_begin();
      chk("wrap_addr", {30'd0, bus_if.buf_addr}, 32'(wrap_exp[i]));
      cyc_end();
      bus_if.bus_strobe = 0;
    end
    tick();

    // Abort coinciding with a strobe at remaining=2.
    seen_done = 0;
    launch(1'b0, 1'b1, 4, 0);
    strobes(2, 1'b0);
    bus_if.abort = 1; bus_if.bus_strobe = 1;
    cyc_begin();
    chk("abort_we", {31'd0, bus_if.buf_we}, 32'd0);
    cyc_end();
    clr();
    cyc_begin();
    chk("abort_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("abort_rem", {16'd0, bus_if.remaining}, 32'd2);
    chk("abort_addr", {30'd0, bus_if.buf_addr}, 32'd2);
    cyc_end();
    repeat (3) tick();
    chk("abort_no_done", 32'(seen_done), 32'd0);

    // Reset in the middle of a DMA transfer.
    seen_done = 0;
    launch(1'b1, 1'b1, 5, 0);
    strobes(2, 1'b1);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("mid_rst_dmarq", {31'd0, bus_if.dmarq}, 32'd0);
    chk("mid_rst_rem", {16'd0, bus_if.remaining}, 32'd0);
    chk("mid_rst_addr", {30'd0, bus_if.buf_addr}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    repeat (4) tick();
    chk("mid_rst_no_done", 32'(seen_done), 32'd0);

    // Random traffic against the reference.
    for (int c = 0; c < 3000; c++) begin
      bus_if.start      = ($urandom_range(7) == 0);
      bus_if.mode       = 1'($urandom_range(1));
      bus_if.dir        = 1'($urandom_range(1));
      bus_if.xfer_len   = CW'($urandom_range(9));
      bus_if.blk_len    = 3'($urandom_range(7));
      bus_if.cpu_ack    = ($urandom_range(3) == 0);
      bus_if.abort      = ($urandom_range(39) == 0);
      bus_if.bus_strobe = 1'($urandom_range(1));
      bus_if.dmack      = ($urandom_range(4) != 0) ? bus_if.mode : ~bus_if.mode;
      tick();
    end
    clr();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ide_xfer_sequencer.md
IDE_XFER_SEQUENCER -- requirements
Module: ide_xfer_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning data-buffer word-address width (depth 2^ADDR_W 16-bit words).
REQ-002 SHALL have parameter CNT_W, default 16, meaning transfer-length counter width in words.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse from the CPU side that launches a transfer.
REQ-006 SHALL have port mode  input  1  sampled at start; 0=PIO, 1=multiword DMA.
REQ-007 SHALL have port dir  input  1  sampled at start; 1=host writes to buffer, 0=host reads from buffer.
REQ-008 SHALL have port xfer_len  input  CNT_W  sampled at start; total words.
REQ-009 SHALL have port blk_len  input  ADDR_W+1  sampled at start; words per block, 0 meaning 2^ADDR_W.
REQ-010 SHALL have port cpu_ack  input  1  one-cycle pulse from the CPU releasing the next block.
REQ-011 SHALL have port abort  input  1  one-cycle pulse that terminates the transfer.
REQ-012 SHALL have port bus_strobe  input  1  one-cycle pulse per completed host data-word cycle (edge-detected DIOR/DIOW).
REQ-013 SHALL have port dmack  input  1  decoded DMACK, active-high.
REQ-014 SHALL have port buf_addr  output  ADDR_W  buffer word address for the current host word.
REQ-015 SHALL have port buf_we  output  1  buffer write enable.
REQ-016 SHALL have port drq  output  1  status DRQ bit.
REQ-017 SHALL have port dmarq  output  1  DMARQ level.
REQ-018 SHALL have port busy  output  1  transfer in progress (state not IDLE).
REQ-019 SHALL have port remaining  output  CNT_W  words left.
REQ-020 SHALL have port block_irq  output  1  one-cycle pulse at block end.
REQ-021 SHALL have port done  output  1  one-cycle pulse at transfer completion.
REQ-022 SHALL have port overrun  output  1  sticky flag for unexpected host strobe.

Function
REQ-023 SHALL implement the states IDLE, XFER and BLKWAIT.
REQ-024 SHALL, in IDLE on start with xfer_len!=0: load remaining=xfer_len, blk_cnt=blk_len, buf_addr=0, latch mode/dir, clear overrun, enter XFER next cycle.
REQ-025 SHALL, on start with xfer_len==0, stay in IDLE and pulse done the following cycle.
REQ-026 SHALL define valid strobe = bus_strobe & (state==XFER) & (latched mode ? dmack : ~dmack).
REQ-027 SHALL drive buf_we = valid strobe & latched dir (combinational, same cycle) at the current buf_addr.
REQ-028 SHALL, per valid strobe: buf_addr+1 modulo 2^ADDR_W (wrap, no stall), remaining-1, blk_cnt-1.
REQ-029 SHALL, when remaining becomes 0: go to IDLE and pulse done for 1 cycle; done takes priority over block_irq when both end together.
REQ-030 SHALL, when blk_cnt becomes 0 and remaining!=0: go to BLKWAIT and pulse block_irq for 1 cycle.
REQ-031 SHALL, in BLKWAIT on cpu_ack: reload blk_cnt=latched blk_len and return to XFER; buf_addr is not reset.
REQ-032 SHALL drive drq = (state==XFER) & PIO, combinational from state.
REQ-033 SHALL register dmarq: set on entry to XFER in DMA mode; cleared the cycle after dmack is high while remaining==1 (early last-word negation); cleared on leaving XFER.
REQ-034 SHALL set overrun on bus_strobe in BLKWAIT, or in XFER with the wrong dmack qualification; such strobes have no other effect.
REQ-035 SHALL, on abort in any state: go to IDLE next cycle, drq=dmarq=0, no done or block_irq pulse; remaining and buf_addr hold their values.
REQ-036 SHALL give abort priority over start, cpu_ack and bus_strobe in the same cycle.
REQ-037 SHALL ignore start while busy, and ignore cpu_ack outside BLKWAIT.

Reset
REQ-038 SHALL, on rst asserted, asynchronously force state=IDLE, buf_addr=0, remaining=0, blk_cnt=0, buf_we=0, drq=0, dmarq=0, busy=0, block_irq=0, done=0, overrun=0.
REQ-039 SHALL, on rst asserted mid-transfer, take no completion action and issue no pulses after rst is released.

Verification
REQ-040 SHALL cover PIO read: xfer_len=4, blk_len=4, 4 strobes -> buf_addr 0..3, buf_we=0, done once, no block_irq.
REQ-041 SHALL cover PIO write with blocks: xfer_len=6, blk_len=2 -> block_irq after words 2 and 4, drq low in BLKWAIT, buf_we on every strobe, done after word 6.
REQ-042 SHALL cover DMA: xfer_len=3 -> dmarq high; the cycle after dmack is seen with remaining==1, dmarq is low; a strobe with dmack=0 sets overrun.
REQ-043 SHALL cover wrap: ADDR_W=2, xfer_len=6, blk_len=0 -> buf_addr sequence 0,1,2,3,0,1, block_irq after word 4.
REQ-044 SHALL cover abort+strobe in the same cycle at remaining=2 -> IDLE, remaining stays 2, no done.
REQ-045 SHALL cover rst mid-transfer -> all outputs at reset values, and no done after release.
